// File: rtl/skt5_pkg.sv
// Shared definitions for the registered ripple-carry adder: default width,
// the result-flag bundle and its reset value.
package skt5_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic cout;
        logic zero;
        logic ovf;
    } flags_t;

    // An all-zero sum after reset, so the zero flag starts asserted.
    localparam flags_t FLAGS_RESET = '{cout: 1'b0, zero: 1'b1, ovf: 1'b0};

endpackage

// File: rtl/skt5_reg_adder_full_adder_cell.sv
// One-bit full adder; the top chains WIDTH of these into a ripple-carry adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/skt5_reg_adder.sv
// Registered ripple-carry adder {cout, s} = a + b + cin with zero and signed
// overflow flags and a one-cycle valid strobe.
module skt5_reg_adder
    import skt5_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    flags_t           flags_next;

    logic [WIDTH-1:0] s_reg;
    flags_t           flags_reg;
    logic             out_valid_reg;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            full_adder_cell u_cell (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (carry[gi]),
                .s  (sum_next[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_comb begin
        flags_next      = FLAGS_RESET;
        flags_next.cout = carry[WIDTH];
        flags_next.zero = (sum_next == '0);
        flags_next.ovf  = carry[WIDTH] ^ carry[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg         <= '0;
            flags_reg     <= FLAGS_RESET;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                s_reg     <= sum_next;
                flags_reg <= flags_next;
            end
        end
    end

    assign s         = s_reg;
    assign cout      = flags_reg.cout;
    assign zero      = flags_reg.zero;
    assign ovf       = flags_reg.ovf;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_skt5_reg_adder.sv
// Bench for skt5_reg_adder: directed sums, hold/gating, exhaustive sweep and
// reset behaviour, checked against an arithmetic model of a + b + cin.
module tb_skt5_reg_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         out_valid;

    int total = 0;
    int bad   = 0;

    int   exp_s;
    logic exp_cout;
    logic exp_zero;
    logic exp_ovf;
    logic exp_valid;

    skt5_reg_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    task automatic model_add(input int av, input int bv, input int cv);
        int full;
        int ssum;
        full     = av + bv + cv;
        exp_s    = full % (1 << W);
        exp_cout = (full >= (1 << W));
        exp_zero = (exp_s == 0);
        ssum     = to_signed(av) + to_signed(bv) + cv;
        exp_ovf  = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
    endtask

    task automatic model_reset();
        exp_s     = 0;
        exp_cout  = 1'b0;
        exp_zero  = 1'b1;
        exp_ovf   = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        int sv;
        sv = (^s === 1'bx) ? -1 : int'(s);
        chk({tag, ".s"}, sv, exp_s);
        chk({tag, ".cout"}, int'(cout), int'(exp_cout));
        chk({tag, ".zero"}, int'(zero), int'(exp_zero));
        chk({tag, ".ovf"}, int'(ovf), int'(exp_ovf));
        chk({tag, ".out_valid"}, int'(out_valid), int'(exp_valid));
        $display("%s: in_valid=%0b a=%0d b=%0d cin=%0b -> s=%0d cout=%0b zero=%0b ovf=%0b out_valid=%0b",
                 tag, in_valid, a, b, cin, s, cout, zero, ovf, out_valid);
    endtask

    // One edge: drive at the falling edge, check just after the rising edge.
    task automatic step(input string tag, input logic v, input int av, input int bv, input int cv);
        @(negedge clk);
        in_valid = v;
        a        = av[W-1:0];
        b        = bv[W-1:0];
        cin      = cv[0];
        if (v) model_add(av, bv, cv);
        exp_valid = v;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = W'($urandom_range(0, (1 << W) - 1));
            b        = W'($urandom_range(0, (1 << W) - 1));
            cin      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_release_idle");

        step("first_valid", 1'b1, 6, 3, 0);

        step("sum_6_3_0", 1'b1, 6, 3, 0);
        step("sum_6_3_1", 1'b1, 6, 3, 1);
        step("sum_12_3_0", 1'b1, 12, 3, 0);
        step("carry_12_5_0", 1'b1, 12, 5, 0);
        step("carry_12_5_1", 1'b1, 12, 5, 1);
        step("carry_15_0_1", 1'b1, 15, 0, 1);
        step("zero_0_0_0", 1'b1, 0, 0, 0);
        step("ovf_7_1_0", 1'b1, 7, 1, 0);
        step("ovf_8_8_0", 1'b1, 8, 8, 0);

        step("hold_load", 1'b1, 6, 3, 0);
        step("hold_idle1", 1'b0, 13, 14, 1);
        step("hold_idle2", 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);

        for (int ai = 0; ai < (1 << W); ai++)
            for (int bi = 0; bi < (1 << W); bi++)
                for (int ci = 0; ci < 2; ci++)
                    step("exhaustive", 1'b1, ai, bi, ci);

        for (int i = 0; i < 20; i++)
            step("random", 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)));

        step("pre_reset", 1'b1, 9, 9, 1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'd11;
        b        = 4'd7;
        cin      = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midstream_reset_async");
        @(posedge clk);
        #1;
        check_all("midstream_reset_edge");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("midstream_no_stale_valid");

        step("after_reset", 1'b1, 12, 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
